// File: rtl/wb_slave_bridge.sv
// Wishbone classic slave bridge: registers a window-matched request, drives the
// module decoder (we_o/addr_o/reg_addr_o/wdata_o/sel_o) and acks with rdata_i.
// Ports: wb_clk_i/wb_rst_i (sync, active-high), wbs_* slave bus, decoder side
// we_o, addr_o, reg_addr_o, wdata_o, sel_o, rdata_i; err_o sticky bad select.
// Optional: define ADDR_CHECK_EN to block writes/flag reads to invalid selects.
module wb_slave_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned N_MODULES   = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        we_o,
  output logic [2:0]  addr_o,
  output logic [5:0]  reg_addr_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  sel_o,
  input  logic [31:0] rdata_i,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic [2:0]  mod_q;
  logic [5:0]  off_q;
  logic [31:0] wdat_q;
  logic [3:0]  bsel_q;
  logic        we_q;
  logic [31:0] rdat_q;

  logic hit;
  logic first;
  logic last;
  logic busy;
  logic bad_sel;
  logic bad;
  logic to_ack;

  assign hit   = wbs_cyc_i & wbs_stb_i &
                 (wbs_adr_i[31:11] == BASE_ADDR[31:11]);
  assign first = cnt_q == 4'd0;
  assign last  = cnt_q == 4'(WAIT_CYCLES);
  assign busy  = state_q != IDLE;

  assign bad_sel = (mod_q == 3'd0) ||
                   (32'(mod_q) > N_MODULES);

`ifdef ADDR_CHECK_EN
  logic err_q;

  assign bad   = bad_sel;
  assign err_o = err_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      err_q <= 1'b0;
    end else if (to_ack && bad) begin
      err_q <= 1'b1;
    end
  end

  logic unused_adr;
  assign unused_adr = ^wbs_adr_i[1:0];
`else
  assign bad   = 1'b0;
  assign err_o = 1'b0;

  logic unused_adr;
  assign unused_adr = ^{wbs_adr_i[1:0], bad_sel};
`endif

  // Leaving the last ACCESS cycle with the bus still held.
  assign to_ack = (state_q == ACCESS) && (state_d == ACK);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (hit) state_d = ACCESS;
      end
      ACCESS: begin
        if (!wbs_cyc_i) state_d = IDLE;
        else if (last) state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mod_q   <= '0;
      off_q   <= '0;
      wdat_q  <= '0;
      bsel_q  <= '0;
      we_q    <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      // cnt_q is 0 in the first ACCESS cycle, WAIT_CYCLES in the last.
      if (state_q == ACCESS && state_d == ACCESS) begin
        cnt_q <= cnt_q + 4'd1;
      end else begin
        cnt_q <= '0;
      end
      if (state_q == IDLE && hit) begin
        mod_q  <= wbs_adr_i[10:8];
        off_q  <= wbs_adr_i[7:2];
        wdat_q <= wbs_dat_i;
        bsel_q <= wbs_sel_i;
        we_q   <= wbs_we_i;
      end
      // Read data lives only for the ACK cycle.
      if (to_ack) begin
        if (we_q) rdat_q <= '0;
        else if (bad) rdat_q <= 32'hDEAD_BEEF;
        else rdat_q <= rdata_i;
      end else begin
        rdat_q <= '0;
      end
    end
  end

  assign wbs_ack_o  = state_q == ACK;
  assign wbs_dat_o  = rdat_q;
  assign we_o       = (state_q == ACCESS) & first & we_q & ~bad;
  assign addr_o     = busy ? mod_q  : '0;
  assign reg_addr_o = busy ? off_q  : '0;
  assign wdata_o    = busy ? wdat_q : '0;
  assign sel_o      = busy ? bsel_q : '0;

endmodule

// File: tb/tb_wb_slave_bridge.sv
// Bench for wb_slave_bridge: directed bus transfers, a timing-rule model
// compared every cycle, and literal expectations for the key scenarios.
module tb_wb_slave_bridge;

  localparam int W = 1;
`ifdef ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat;
  logic        ack;
  logic [31:0] dat_o;
  logic        we_o;
  logic [2:0]  addr_o;
  logic [5:0]  reg_addr_o;
  logic [31:0] wdata_o;
  logic [3:0]  sel_o;
  logic [31:0] rdata;
  logic        err_o;

  always #5 clk = ~clk;

  wb_slave_bridge #(
    .BASE_ADDR  (32'h3000_0000),
    .WAIT_CYCLES(W),
    .N_MODULES  (4)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .we_o      (we_o),
    .addr_o    (addr_o),
    .reg_addr_o(reg_addr_o),
    .wdata_o   (wdata_o),
    .sel_o     (sel_o),
    .rdata_i   (rdata),
    .err_o     (err_o)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_ack  = 0;
  int n_we   = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic bit sel_bad(input logic [2:0] s);
    return CHK && (s == 3'd0 || s > 3'd4);
  endfunction

  // Model: a transfer accepted at edge k is ACCESS for edges k..k+W
  // (cycles k+1..k+1+W) and ACK after edge k+W+1.
  int          edge_n = 0;
  bit          m_act  = 1'b0;
  int          m_k    = 0;
  bit          m_we;
  logic [2:0]  m_sel;
  logic [5:0]  m_off;
  logic [31:0] m_wd;
  logic [3:0]  m_bs;
  logic [31:0] m_rc = '0;
  bit          m_err = 1'b0;

  always @(posedge clk) begin : model
    bit was;
    int d;
    edge_n++;
    if (rst) begin
      m_act = 1'b0;
      m_err = 1'b0;
    end else begin
      was = m_act;
      if (m_act) begin
        d = edge_n - m_k;
        if (d <= W + 1 && !cyc) begin
          m_act = 1'b0;
        end else if (d == W + 1) begin
          if (m_we) m_rc = '0;
          else if (sel_bad(m_sel)) m_rc = 32'hDEAD_BEEF;
          else m_rc = rdata;
          if (sel_bad(m_sel)) m_err = 1'b1;
        end else if (d == W + 2) begin
          m_act = 1'b0;
        end
      end
      if (!was && cyc && stb &&
          (adr & 32'hFFFF_F800) == 32'h3000_0000) begin
        m_act = 1'b1;
        m_k   = edge_n;
        m_we  = we;
        m_sel = adr[10:8];
        m_off = adr[7:2];
        m_wd  = dat;
        m_bs  = sel;
      end
    end
  end

  always @(negedge clk) begin : compare
    int d;
    bit e_ack;
    bit e_we;
    if (started) begin
      d     = edge_n - m_k;
      e_ack = m_act && d == W + 1;
      e_we  = m_act && d == 0 && m_we && !sel_bad(m_sel);
      chk("ack", 32'(ack), 32'(e_ack));
      chk("we_o", 32'(we_o), 32'(e_we));
      chk("addr_o", 32'(addr_o), m_act ? 32'(m_sel) : 32'd0);
      chk("reg_addr_o", 32'(reg_addr_o), m_act ? 32'(m_off) : 32'd0);
      chk("wdata_o", wdata_o, m_act ? m_wd : 32'd0);
      chk("sel_o", 32'(sel_o), m_act ? 32'(m_bs) : 32'd0);
      chk("dat_o", dat_o, e_ack ? m_rc : 32'd0);
      chk("err_o", 32'(err_o), 32'(m_err));
      if (ack) n_ack++;
      if (we_o) n_we++;
    end
  end

  task automatic req(input logic w, input logic [31:0] a,
                     input logic [31:0] d);
    cyc = 1'b1;
    stb = 1'b1;
    we  = w;
    adr = a;
    dat = d;
    sel = 4'hF;
  endtask

  task automatic idle();
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    adr = '0;
    dat = '0;
    sel = '0;
  endtask

  int a0;
  int w0;

  initial begin
    rst   = 1'b1;
    rdata = '0;
    idle();
    @(posedge clk);
    started = 1'b1;
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_addr", 32'(addr_o), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: write
    req(1'b1, 32'h3000_0104, 32'h1234_5678);
    @(negedge clk);
    chk("t1_we", 32'(we_o), 32'd1);
    chk("t1_addr", 32'(addr_o), 32'd1);
    chk("t1_reg", 32'(reg_addr_o), 32'd1);
    chk("t1_wdata", wdata_o, 32'h1234_5678);
    @(negedge clk);
    chk("t1_we2", 32'(we_o), 32'd0);
    chk("t1_ack2", 32'(ack), 32'd0);
    @(negedge clk);
    chk("t1_ack3", 32'(ack), 32'd1);
    idle();
    @(negedge clk);
    chk("t1_ack4", 32'(ack), 32'd0);

    // 2: read
    w0 = n_we;
    rdata = 32'hCAFE_F00D;
    req(1'b0, 32'h3000_0208, 32'h0);
    @(negedge clk);
    chk("t2_addr", 32'(addr_o), 32'd2);
    chk("t2_reg", 32'(reg_addr_o), 32'd2);
    @(negedge clk);
    @(negedge clk);
    chk("t2_ack", 32'(ack), 32'd1);
    chk("t2_dat", dat_o, 32'hCAFE_F00D);
    idle();
    @(negedge clk);
    chk("t2_dat_clr", dat_o, 32'd0);
    chk("t2_no_we", 32'(n_we), 32'(w0));

    // 3: outside the window
    a0 = n_ack;
    req(1'b1, 32'h3100_0100, 32'h5555_AAAA);
    repeat (10) begin
      @(negedge clk);
      chk("t3_addr", 32'(addr_o), 32'd0);
      chk("t3_we", 32'(we_o), 32'd0);
    end
    idle();
    @(negedge clk);
    chk("t3_noack", 32'(n_ack), 32'(a0));

    // 4: write aborted in its last ACCESS cycle
    a0 = n_ack;
    w0 = n_we;
    req(1'b1, 32'h3000_0104, 32'hAAAA_5555);
    @(negedge clk);
    chk("t4_we", 32'(we_o), 32'd1);
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    chk("t4_noack", 32'(n_ack), 32'(a0));
    chk("t4_one_we", 32'(n_we), 32'(w0 + 1));
    rdata = 32'h0BAD_F00D;
    req(1'b0, 32'h3000_0300, 32'h0);
    @(negedge clk);
    chk("t4_addr", 32'(addr_o), 32'd3);
    @(negedge clk);
    @(negedge clk);
    chk("t4_ack", 32'(ack), 32'd1);
    chk("t4_dat", dat_o, 32'h0BAD_F00D);
    idle();
    @(negedge clk);

    // 5: reset mid read
    a0 = n_ack;
    rdata = 32'h1111_2222;
    req(1'b0, 32'h3000_0208, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
    chk("t5_addr", 32'(addr_o), 32'd0);
    chk("t5_reg", 32'(reg_addr_o), 32'd0);
    chk("t5_ack", 32'(ack), 32'd0);
    chk("t5_dat", dat_o, 32'd0);
    repeat (3) @(negedge clk);
    chk("t5_noack", 32'(n_ack), 32'(a0));

    // 6: select 0
    rdata = 32'h0;
    req(1'b0, 32'h3000_0000, 32'h0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t6_ack", 32'(ack), 32'd1);
    chk("t6_dat", dat_o, CHK ? 32'hDEAD_BEEF : 32'd0);
    idle();
    repeat (2) @(negedge clk);
    chk("t6_err", 32'(err_o), 32'(CHK));

    // 7: request held across two transfers
    a0 = n_ack;
    rdata = 32'h5A5A_5A5A;
    req(1'b0, 32'h3000_0104, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 3 || i == 7) chk("t7_ack", 32'(ack), 32'd1);
      if (i == 4) chk("t7_gap", 32'(addr_o), 32'd0);
    end
    idle();
    repeat (3) @(negedge clk);
    chk("t7_two_acks", 32'(n_ack), 32'(a0 + 2));

    // 8: reset and request on the same edge
    rst = 1'b1;
    req(1'b1, 32'h3000_0104, 32'h7777_7777);
    @(negedge clk);
    chk("t8_addr", 32'(addr_o), 32'd0);
    chk("t8_we", 32'(we_o), 32'd0);
    rst = 1'b0;
    idle();
    @(negedge clk);

    // 9: write to select 5
    w0 = n_we;
    req(1'b1, 32'h3000_0504, 32'h0F0F_0F0F);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t9_ack", 32'(ack), 32'd1);
    idle();
    repeat (3) @(negedge clk);
    chk("t9_we", 32'(n_we), CHK ? 32'(w0) : 32'(w0 + 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
